// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the decode stage.
//   - word/field widths and the bubble encoding
//   - FSM state encoding (S_FIRST / S_SKIP)
//   - instruction class encoding
//   - bit positions of every field within a 16-bit instruction word
// Optional feature macro used by the importers: DECODE_ILLEGAL_TRAP_EN.
package decode_pkg;

  localparam int WORD_W  = 16;
  localparam int OPC_W   = 8;
  localparam int REG_W   = 6;
  localparam int CLASS_W = 2;

  // Filler word that fetch inserts when it has nothing to offer.
  localparam logic [WORD_W-1:0] BUBBLE_WORD = 16'h0001;

  typedef enum logic {
    S_FIRST = 1'b0,  // older word starts a new instruction
    S_SKIP  = 1'b1   // older word is the already-consumed second half
  } state_e;

  typedef enum logic [CLASS_W-1:0] {
    CLASS_0    = 2'b00,
    CLASS_1    = 2'b01,
    CLASS_2    = 2'b10,
    CLASS_RSVD = 2'b11   // reserved for 16-bit encodings
  } class_e;

  // Field positions, first word (W)
  localparam int IS32_BIT = 15;
  localparam int CLS_HI   = 14;
  localparam int CLS_LO   = 13;
  // Field positions shared by both words
  localparam int OP_HI    = 12;
  localparam int OP_LO    = 9;
  localparam int RD_HI    = 8;
  localparam int RD_LO    = 6;
  localparam int RA_HI    = 5;
  localparam int RA_LO    = 3;
  localparam int RB_HI    = 2;
  localparam int RB_LO    = 0;
  // Reserved bits of the second word (X)
  localparam int RSVD_HI  = 15;
  localparam int RSVD_LO  = 13;

endpackage

// File: rtl/decode_fields.sv
// decode_fields: purely combinational field extractor.
// Splits the older word (W) and the newer word (X) into opcode, register
// and immediate fields, choosing the 16-bit or 32-bit layout from W[15].
// Ports:
//   older_i    first word of the candidate instruction
//   newer_i    word following it (second half when 32-bit)
//   is32_o     W[15]
//   cls_o      W[14:13]
//   opcode_o   {op_hi,op_lo} or {4'h0,op_lo}
//   rd_o/ra_o/rb_o  {hi,lo} or {3'b0,lo}
//   imm_o      sign-extended 12-bit or 6-bit immediate
//   illegal_o  (only with DECODE_ILLEGAL_TRAP_EN) illegal encoding seen
module decode_fields
  import decode_pkg::*;
#(
  parameter int PC_WIDTH = 20
) (
  input  logic [WORD_W-1:0]   older_i,
  input  logic [WORD_W-1:0]   newer_i,
  output logic                is32_o,
  output logic [CLASS_W-1:0]  cls_o,
  output logic [OPC_W-1:0]    opcode_o,
  output logic [REG_W-1:0]    rd_o,
  output logic [REG_W-1:0]    ra_o,
  output logic [REG_W-1:0]    rb_o,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic                illegal_o,
`endif
  output logic [PC_WIDTH-1:0] imm_o
);

  logic [3:0]  op_lo, op_hi;
  logic [2:0]  rd_lo, ra_lo, rb_lo, rd_hi, ra_hi, rb_hi;
  logic [11:0] imm12;
  logic [5:0]  imm6;

  assign op_lo = older_i[OP_HI:OP_LO];
  assign rd_lo = older_i[RD_HI:RD_LO];
  assign ra_lo = older_i[RA_HI:RA_LO];
  assign rb_lo = older_i[RB_HI:RB_LO];
  assign op_hi = newer_i[OP_HI:OP_LO];
  assign rd_hi = newer_i[RD_HI:RD_LO];
  assign ra_hi = newer_i[RA_HI:RA_LO];
  assign rb_hi = newer_i[RB_HI:RB_LO];

  assign is32_o = older_i[IS32_BIT];
  assign cls_o  = older_i[CLS_HI:CLS_LO];

  assign imm12 = {ra_hi, rb_hi, ra_lo, rb_lo};
  assign imm6  = {ra_lo, rb_lo};

  always_comb begin
    opcode_o = {4'h0, op_lo};
    rd_o     = {3'b000, rd_lo};
    ra_o     = {3'b000, ra_lo};
    rb_o     = {3'b000, rb_lo};
    imm_o    = {{(PC_WIDTH-6){imm6[5]}}, imm6};
    if (is32_o) begin
      opcode_o = {op_hi, op_lo};
      rd_o     = {rd_hi, rd_lo};
      ra_o     = {ra_hi, ra_lo};
      rb_o     = {rb_hi, rb_lo};
      imm_o    = {{(PC_WIDTH-12){imm12[11]}}, imm12};
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  // 16-bit: reserved class. 32-bit: non-zero reserved bits in X.
  assign illegal_o = is32_o ? (newer_i[RSVD_HI:RSVD_LO] != 3'b000)
                            : (cls_o == CLASS_RSVD);
`else
  // Reserved bits only matter for illegal checking.
  logic unused_rsvd;
  assign unused_rsvd = ^newer_i[RSVD_HI:RSVD_LO];
`endif

endmodule

// File: rtl/decode.sv
// decode: instruction decode stage directly behind fetch.
// Fetch presents a two-word window {older, newer} that slides one word per
// unstalled cycle. A 32-bit instruction is issued when its first word is
// the older word; the following cycle (its second half now older) is
// skipped. Bubble words are never issued. All outputs are registered.
// Ports:
//   clock, reset     clock and synchronous active-high reset
//   stop             freeze: all state and outputs hold
//   flush            discard in-flight decode, back to S_FIRST
//   fetch_word       {older[31:16], newer[15:0]}
//   fetch_pc         address of the older word
//   dec_*            registered decoded fields; qualify with dec_valid
//   dec_illegal      (only with DECODE_ILLEGAL_TRAP_EN) illegal encoding
//   dbg_state        current FSM state (0 = S_FIRST, 1 = S_SKIP)
// Optional macro: DECODE_ILLEGAL_TRAP_EN.
// Priority: reset > stop > flush > FSM.
module decode
  import decode_pkg::*;
#(
  parameter int PC_WIDTH   = 20,
  parameter int WORD_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stop,
  input  logic                    flush,
  input  logic [2*WORD_WIDTH-1:0] fetch_word,
  input  logic [PC_WIDTH-1:0]     fetch_pc,
  output logic                    dec_valid,
  output logic                    dec_is32,
  output logic [1:0]              dec_class,
  output logic [7:0]              dec_opcode,
  output logic [5:0]              dec_rd,
  output logic [5:0]              dec_ra,
  output logic [5:0]              dec_rb,
  output logic [PC_WIDTH-1:0]     dec_imm,
  output logic [PC_WIDTH-1:0]     dec_pc,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic                    dec_illegal,
`endif
  output logic                    dbg_state
);

  logic [WORD_W-1:0] older, newer;
  assign older = fetch_word[2*WORD_WIDTH-1:WORD_WIDTH];
  assign newer = fetch_word[WORD_WIDTH-1:0];

  logic                f_is32;
  logic [CLASS_W-1:0]  f_cls;
  logic [OPC_W-1:0]    f_opcode;
  logic [REG_W-1:0]    f_rd, f_ra, f_rb;
  logic [PC_WIDTH-1:0] f_imm;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                f_illegal;
`endif

  decode_fields #(.PC_WIDTH(PC_WIDTH)) u_fields (
    .older_i   (older),
    .newer_i   (newer),
    .is32_o    (f_is32),
    .cls_o     (f_cls),
    .opcode_o  (f_opcode),
    .rd_o      (f_rd),
    .ra_o      (f_ra),
    .rb_o      (f_rb),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .illegal_o (f_illegal),
`endif
    .imm_o     (f_imm)
  );

  // Drop a bubble, or a 32-bit start whose second half is not yet there.
  logic drop;
  assign drop = (older == BUBBLE_WORD) || (f_is32 && (newer == BUBBLE_WORD));

  state_e              state_q;
  logic                valid_q, is32_q;
  logic [CLASS_W-1:0]  cls_q;
  logic [OPC_W-1:0]    opcode_q;
  logic [REG_W-1:0]    rd_q, ra_q, rb_q;
  logic [PC_WIDTH-1:0] imm_q, pc_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic                illegal_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FIRST;
      valid_q   <= 1'b0;
      is32_q    <= 1'b0;
      cls_q     <= '0;
      opcode_q  <= '0;
      rd_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else if (!stop) begin
      // Default: non-issuing cycle; field registers keep their values.
      valid_q   <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
      if (flush) begin
        state_q <= S_FIRST;
      end else begin
        case (state_q)
          S_FIRST: begin
            if (!drop) begin
              valid_q   <= 1'b1;
              is32_q    <= f_is32;
              cls_q     <= f_cls;
              opcode_q  <= f_opcode;
              rd_q      <= f_rd;
              ra_q      <= f_ra;
              rb_q      <= f_rb;
              imm_q     <= f_imm;
              pc_q      <= fetch_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
              illegal_q <= f_illegal;
`endif
              if (f_is32) state_q <= S_SKIP;
            end
          end
          S_SKIP:  state_q <= S_FIRST;
          default: state_q <= S_FIRST;
        endcase
      end
    end
  end

  assign dec_valid   = valid_q;
  assign dec_is32    = is32_q;
  assign dec_class   = cls_q;
  assign dec_opcode  = opcode_q;
  assign dec_rd      = rd_q;
  assign dec_ra      = ra_q;
  assign dec_rb      = rb_q;
  assign dec_imm     = imm_q;
  assign dec_pc      = pc_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign dec_illegal = illegal_q;
`endif
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed-vector bench for decode with hand-computed expectations.
module tb_decode;

  localparam int PW = 20;

  logic          clock = 1'b0;
  logic          reset, stop, flush;
  logic [31:0]   fetch_word;
  logic [PW-1:0] fetch_pc;
  logic          dec_valid, dec_is32;
  logic [1:0]    dec_class;
  logic [7:0]    dec_opcode;
  logic [5:0]    dec_rd, dec_ra, dec_rb;
  logic [PW-1:0] dec_imm, dec_pc;
  logic          dbg_state;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic          dec_illegal;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  decode #(.PC_WIDTH(PW), .WORD_WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .stop       (stop),
    .flush      (flush),
    .fetch_word (fetch_word),
    .fetch_pc   (fetch_pc),
    .dec_valid  (dec_valid),
    .dec_is32   (dec_is32),
    .dec_class  (dec_class),
    .dec_opcode (dec_opcode),
    .dec_rd     (dec_rd),
    .dec_ra     (dec_ra),
    .dec_rb     (dec_rb),
    .dec_imm    (dec_imm),
    .dec_pc     (dec_pc),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .dec_illegal(dec_illegal),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] w, input logic [PW-1:0] pc);
    fetch_word = w;
    fetch_pc   = pc;
    step();
  endtask

  task automatic expect_issue(input string tag, input logic is32, input logic [1:0] cls,
                              input logic [7:0] op, input logic [5:0] rd, input logic [5:0] ra,
                              input logic [5:0] rb, input logic [PW-1:0] imm,
                              input logic [PW-1:0] pc, input logic st);
    check({tag, ".valid"}, 32'(dec_valid), 32'd1);
    check({tag, ".is32"},  32'(dec_is32),  32'(is32));
    check({tag, ".class"}, 32'(dec_class), 32'(cls));
    check({tag, ".op"},    32'(dec_opcode), 32'(op));
    check({tag, ".rd"},    32'(dec_rd),    32'(rd));
    check({tag, ".ra"},    32'(dec_ra),    32'(ra));
    check({tag, ".rb"},    32'(dec_rb),    32'(rb));
    check({tag, ".imm"},   32'(dec_imm),   32'(imm));
    check({tag, ".pc"},    32'(dec_pc),    32'(pc));
    check({tag, ".state"}, 32'(dbg_state), 32'(st));
  endtask

  task automatic expect_idle(input string tag, input logic st, input logic [7:0] held_op);
    check({tag, ".valid"}, 32'(dec_valid), 32'd0);
    check({tag, ".state"}, 32'(dbg_state), 32'(st));
    check({tag, ".held_op"}, 32'(dec_opcode), 32'(held_op));
  endtask

  task automatic expect_zero(input string tag);
    check({tag, ".valid"}, 32'(dec_valid), 32'd0);
    check({tag, ".is32"},  32'(dec_is32),  32'd0);
    check({tag, ".class"}, 32'(dec_class), 32'd0);
    check({tag, ".op"},    32'(dec_opcode), 32'd0);
    check({tag, ".regs"},  32'({dec_rd, dec_ra, dec_rb}), 32'd0);
    check({tag, ".imm"},   32'(dec_imm),   32'd0);
    check({tag, ".pc"},    32'(dec_pc),    32'd0);
    check({tag, ".state"}, 32'(dbg_state), 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check({tag, ".illegal"}, 32'(dec_illegal), 32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; stop = 1'b0; flush = 1'b0;
    fetch_word = 32'hA2D1_0447; fetch_pc = 20'h00003;
    step(); step();
    expect_zero("reset");
    reset = 1'b0;

    // 16-bit: 22D1 -> class1 op1 rd3 ra2 rb1 imm 0x11
    drive(32'h22D1_0001, 20'd5);
    expect_issue("i16", 1'b0, 2'd1, 8'h01, 6'd3, 6'd2, 6'd1, 20'h00011, 20'd5, 1'b0);

    // 32-bit: A2D1 + 0447
    drive(32'hA2D1_0447, 20'd8);
    expect_issue("i32", 1'b1, 2'd1, 8'h21, 6'h0B, 6'h02, 6'h39, 20'h001D1, 20'd8, 1'b1);
    // second half is older word: skipped, fields hold
    drive(32'h0447_1234, 20'd9);
    expect_idle("skip", 1'b0, 8'h21);
    // 1234: class0 op9 rd0 ra6 rb4 imm 6'b110100 -> negative
    drive(32'h1234_0001, 20'd10);
    expect_issue("neg16", 1'b0, 2'd0, 8'h09, 6'd0, 6'd6, 6'd4, 20'hFFFF4, 20'd10, 1'b0);

    // Bubbles for three cycles
    for (int i = 0; i < 3; i++) begin
      drive(32'h0001_0001, 20'(11 + i));
      expect_idle("bubble", 1'b0, 8'h09);
    end

    // 32-bit start with bubble second half: dropped
    drive(32'hA2D1_0001, 20'd14);
    expect_idle("malformed", 1'b0, 8'h09);

    // Flush in the S_SKIP cycle
    drive(32'hA2D1_0447, 20'd20);
    check("fl_issue.state", 32'(dbg_state), 32'd1);
    flush = 1'b1;
    drive(32'h1234_5678, 20'd21);
    flush = 1'b0;
    expect_idle("flush", 1'b0, 8'h21);
    // 5678: class2 opB rd1 ra7 rb0 imm 6'b111000
    drive(32'h5678_0001, 20'd22);
    expect_issue("post_fl", 1'b0, 2'd2, 8'h0B, 6'd1, 6'd7, 6'd0, 20'hFFFF8, 20'd22, 1'b0);

    // Flush on a cycle that would otherwise issue
    flush = 1'b1;
    drive(32'h22D1_0001, 20'd23);
    flush = 1'b0;
    expect_idle("flush16", 1'b0, 8'h0B);

    // Stop for 4 cycles while in S_SKIP, with flush and fresh words offered
    drive(32'hA2D1_0447, 20'd30);
    stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flush = (i == 2);
      drive(32'h1234_5678, 20'(40 + i));
      expect_issue("stop", 1'b1, 2'd1, 8'h21, 6'h0B, 6'h02, 6'h39, 20'h001D1, 20'd30, 1'b1);
    end
    stop = 1'b0; flush = 1'b0;
    drive(32'h0447_22D1, 20'd31);
    expect_idle("unstop_skip", 1'b0, 8'h21);
    drive(32'h22D1_0001, 20'd32);
    expect_issue("resume", 1'b0, 2'd1, 8'h01, 6'd3, 6'd2, 6'd1, 20'h00011, 20'd32, 1'b0);

    // PC at its top value is carried through unchanged
    drive(32'h1234_0001, 20'hFFFFF);
    expect_issue("pc_top", 1'b0, 2'd0, 8'h09, 6'd0, 6'd6, 6'd4, 20'hFFFF4, 20'hFFFFF, 1'b0);

`ifdef DECODE_ILLEGAL_TRAP_EN
    // 16-bit reserved class 3
    drive(32'h6000_0001, 20'd50);
    check("ill16.valid", 32'(dec_valid), 32'd1);
    check("ill16.ill",   32'(dec_illegal), 32'd1);
    check("ill16.class", 32'(dec_class), 32'd3);
    // 32-bit with X[15:13] = 001
    drive(32'hA2D1_2447, 20'd51);
    check("ill32.valid", 32'(dec_valid), 32'd1);
    check("ill32.ill",   32'(dec_illegal), 32'd1);
    check("ill32.op",    32'(dec_opcode), 32'h21);
    drive(32'h2447_0001, 20'd52);
    check("ill_skip.ill", 32'(dec_illegal), 32'd0);
    drive(32'h22D1_0001, 20'd53);
    check("legal.ill",   32'(dec_illegal), 32'd0);
    check("legal.valid", 32'(dec_valid), 32'd1);
`endif

    // Reset overrides stop
    stop = 1'b1; reset = 1'b1;
    drive(32'hA2D1_0447, 20'd60);
    expect_zero("reset_stop");
    stop = 1'b0; reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
